// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Purpose : processor data-bus bundle between the processor (master) and the
//           data-memory responder (slave).
// Signals : dAddress   - byte address from processor
//           dWriteData - store data
//           MemRead    - read request, held until MemReady
//           MemWrite   - write request, held until MemReady
//           dReadData  - load data, valid while MemReady=1
//           MemReady   - one-cycle completion pulse
//           MemError   - valid with MemReady, 1 = faulted access
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dReadData;
    logic        MemReady;
    logic        MemError;

    modport master (
        output dAddress, dWriteData, MemRead, MemWrite,
        input  dReadData, MemReady, MemError
    );

    modport slave (
        input  dAddress, dWriteData, MemRead, MemWrite,
        output dReadData, MemReady, MemError
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Purpose : data-memory responder with configurable wait states and fault
//           reporting. Serves word accesses from an internal RAM and signals
//           completion with a one-cycle MemReady pulse.
// Ports   : clk - system clock, rising edge
//           rst - synchronous reset, active-high (RAM contents retained)
//           bus - dmem_responder_if.slave (request in, response out)
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | waiting for MemRead/MemWrite; latches the request when seen
//  WAIT   | counting wait states 1..WAIT_STATES on the latched request
//  RESP   | MemReady (and MemError on fault) high for exactly one cycle
//  HOLD   | waiting for the processor to drop its request before re-arming
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          ADDR_BITS   = 9,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus
);

    localparam int         DEPTH = 2 ** (ADDR_BITS - 2);
    localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_next;

    logic [ADDR_BITS-3:0] r_idx;
    logic [31:0]          r_wdata;
    logic                 r_is_write;
    logic                 r_fault;

    logic [31:0]          r_rdata;
    logic                 r_ready;
    logic                 r_error;

    logic [31:0]          r_mem [DEPTH];

    logic                 w_req;
    logic                 w_idle;
    logic                 w_fault_in;
    logic [ADDR_BITS-3:0] w_idx;
    logic [31:0]          w_wdata;
    logic                 w_is_write;
    logic                 w_fault;
    logic                 w_enter_resp;
    logic                 w_commit;

    assign w_req  = bus.MemRead | bus.MemWrite;
    assign w_idle = (r_state == S_IDLE);

    assign w_fault_in = (bus.dAddress[1:0] != 2'b00)
                      | (bus.dAddress[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS])
                      | (bus.MemRead & bus.MemWrite);

    // With zero wait states the response is produced at the acceptance edge,
    // so the live bus values are used in IDLE and the latched copy afterwards.
    assign w_idx      = w_idle ? bus.dAddress[ADDR_BITS-1:2] : r_idx;
    assign w_wdata    = w_idle ? bus.dWriteData              : r_wdata;
    assign w_is_write = w_idle ? bus.MemWrite                : r_is_write;
    assign w_fault    = w_idle ? w_fault_in                  : r_fault;

    assign w_enter_resp = (w_state_next == S_RESP);
    assign w_commit     = w_enter_resp & w_is_write & ~w_fault & ~rst;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_cnt_next   = 4'd0;
                    w_state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt + 4'd1;
                if (w_cnt_next == LP_WS) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: w_state_next = S_HOLD;
            S_HOLD: begin
                if (!w_req) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_is_write <= 1'b0;
            r_fault    <= 1'b0;
            r_rdata    <= 32'd0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_idle && w_req) begin
                r_idx      <= bus.dAddress[ADDR_BITS-1:2];
                r_wdata    <= bus.dWriteData;
                r_is_write <= bus.MemWrite;
                r_fault    <= w_fault_in;
            end
            r_ready <= w_enter_resp;
            r_error <= w_enter_resp & w_fault;
            if (w_enter_resp && !w_fault && !w_is_write) begin
                r_rdata <= r_mem[w_idx];
            end else begin
                r_rdata <= 32'd0;
            end
        end
    end

    // RAM has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    assign bus.dReadData = r_rdata;
    assign bus.MemReady  = r_ready;
    assign bus.MemError  = r_error;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    int          t_sel;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_rd;
    logic        t_wr;

    int checks;
    int failures;

    exp_t        sb[$];
    logic [31:0] mdl [3][128];

    dmem_responder_if if0 ();
    dmem_responder_if if1 ();
    dmem_responder_if if3 ();

    assign if0.dAddress   = t_addr;
    assign if0.dWriteData = t_wdata;
    assign if0.MemRead    = t_rd & (t_sel == 0);
    assign if0.MemWrite   = t_wr & (t_sel == 0);
    assign if1.dAddress   = t_addr;
    assign if1.dWriteData = t_wdata;
    assign if1.MemRead    = t_rd & (t_sel == 1);
    assign if1.MemWrite   = t_wr & (t_sel == 1);
    assign if3.dAddress   = t_addr;
    assign if3.dWriteData = t_wdata;
    assign if3.MemRead    = t_rd & (t_sel == 2);
    assign if3.MemWrite   = t_wr & (t_sel == 2);

    dmem_responder #(.ADDR_BITS(9), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    dmem_responder #(.ADDR_BITS(9), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    dmem_responder #(.ADDR_BITS(9), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
        .clk(clk), .rst(rst), .bus(if3.slave));

    logic [31:0] w_rdata;
    logic        w_ready;
    logic        w_err;

    assign w_rdata = (t_sel == 0) ? if0.dReadData : (t_sel == 1) ? if1.dReadData : if3.dReadData;
    assign w_ready = (t_sel == 0) ? if0.MemReady  : (t_sel == 1) ? if1.MemReady  : if3.MemReady;
    assign w_err   = (t_sel == 0) ? if0.MemError  : (t_sel == 1) ? if1.MemError  : if3.MemError;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access on the selected responder and check its response.
    // keep=1 leaves the request asserted afterwards (held-request test).
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] data,
                             input bit keep);
        exp_t e;
        int   ws;
        logic flt;
        int   lat;
        bit   seen;
        ws    = (t_sel == 0) ? 0 : (t_sel == 1) ? 1 : 3;
        flt   = (addr[1:0] != 2'b00) || (addr[31:9] != 23'd0) || (rd && wr);
        e.data = (!flt && rd) ? mdl[t_sel][addr[8:2]] : 32'd0;
        e.err  = flt;
        e.lat  = ws + 1;
        if (!flt && wr) mdl[t_sel][addr[8:2]] = data;
        sb.push_back(e);

        t_addr  = addr;
        t_wdata = data;
        t_rd    = rd;
        t_wr    = wr;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (w_ready === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        e = sb.pop_front();
        check({tag, "_ready_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"},    32'(lat),  32'(e.lat));
        check({tag, "_rdata"},      w_rdata,   e.data);
        check({tag, "_error"},      32'(w_err), 32'(e.err));
        if (!keep) begin
            t_rd = 1'b0;
            t_wr = 1'b0;
        end
        @(negedge clk);
        check({tag, "_pulse_width"}, 32'(w_ready), 32'd0);
        check({tag, "_rdata_clr"},   w_rdata,      32'd0);
        check({tag, "_error_clr"},   32'(w_err),   32'd0);
        if (!keep) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        t_sel    = 1;
        t_addr   = 32'd0;
        t_wdata  = 32'd0;
        t_rd     = 1'b0;
        t_wr     = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_ready_ws0", 32'(if0.MemReady), 32'd0);
        check("rst_ready_ws1", 32'(if1.MemReady), 32'd0);
        check("rst_ready_ws3", 32'(if3.MemReady), 32'd0);
        check("rst_error_ws1", 32'(if1.MemError), 32'd0);
        check("rst_rdata_ws1", if1.dReadData,     32'd0);
        @(negedge clk);

        // WAIT_STATES=1: basic write/read
        do_access("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_access("rd10", 1'b1, 1'b0, 32'h10, 32'h0,        1'b0);

        // Misaligned write leaves the aligned word alone
        do_access("wr04",   1'b0, 1'b1, 32'h04, 32'hCAFEF00D, 1'b0);
        do_access("wr06mis", 1'b0, 1'b1, 32'h06, 32'h12345678, 1'b0);
        do_access("rd04",   1'b1, 1'b0, 32'h04, 32'h0,        1'b0);

        // Out-of-range read and read+write collision
        do_access("wr08",    1'b0, 1'b1, 32'h08,  32'h0BADCAFE, 1'b0);
        do_access("rd200",   1'b1, 1'b0, 32'h200, 32'h0,        1'b0);
        do_access("rdwr08",  1'b1, 1'b1, 32'h08,  32'h55555555, 1'b0);
        do_access("rd08",    1'b1, 1'b0, 32'h08,  32'h0,        1'b0);

        // Held write: one commit only, no second MemReady while held
        do_access("wr0c_hold", 1'b0, 1'b1, 32'h0C, 32'h00000100, 1'b1);
        for (int i = 0; i < 6; i++) begin
            t_wdata = t_wdata + 32'd1;
            @(negedge clk);
            check("hold_no_ready", 32'(w_ready), 32'd0);
        end
        t_wr = 1'b0;
        repeat (2) @(negedge clk);
        do_access("rd0c", 1'b1, 1'b0, 32'h0C, 32'h0, 1'b0);

        // WAIT_STATES=0 latency
        t_sel = 0;
        @(negedge clk);
        do_access("ws0_wr04", 1'b0, 1'b1, 32'h04, 32'hA5A50004, 1'b0);
        do_access("ws0_rd04", 1'b1, 1'b0, 32'h04, 32'h0,        1'b0);

        // WAIT_STATES=3 latency and reset during WAIT
        t_sel = 2;
        @(negedge clk);
        do_access("ws3_wr04", 1'b0, 1'b1, 32'h04, 32'h3C3C0004, 1'b0);
        do_access("ws3_rd04", 1'b1, 1'b0, 32'h04, 32'h0,        1'b0);
        do_access("ws3_wr20", 1'b0, 1'b1, 32'h20, 32'h11112222, 1'b0);

        t_addr  = 32'h20;
        t_wdata = 32'h99998888;
        t_wr    = 1'b1;
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        t_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(w_ready), 32'd0);
        check("abort_error", 32'(w_err),   32'd0);
        check("abort_rdata", w_rdata,      32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_ready", 32'(w_ready), 32'd0);
        end
        do_access("ws3_rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
